lfsr_random_stream: RTL and testbench
=====================================

Name: lfsr_random_stream

Overview:
- Parametrised Galois LFSR random-number source: generalises the fixed 8-bit generator to any width, tap mask and output range.
- Adds run-time reseeding, zero-state lockup recovery, two range-reduction modes and a valid/ready output handshake.
- Feeds game/test logic that consumes bounded random values at its own pace.

Parameters:
- WIDTH, 16, LFSR state width (>=4).
- TAPS, 16'hB400, Galois feedback mask (WIDTH bits); must describe a maximal-length polynomial.
- LIMIT, 15, largest value delivered; OUT_W = $clog2(LIMIT+1), OUT_W <= WIDTH.
- SEED, 1, reset/default seed; a value of 0 is replaced by 1.
- REJECT, 1, 1 = rejection sampling (discard candidates > LIMIT); 0 = saturate candidate to LIMIT.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  permits LFSR stepping.
- seed_load  in  1  one-cycle strobe: load seed_in into the LFSR.
- seed_in  in  WIDTH  new seed.
- rand_ready  in  1  consumer accepts rand_out this cycle.
- rand_valid  out  1  rand_out holds an unconsumed value.
- rand_out  out  OUT_W  bounded random value, 0..LIMIT.
- lfsr_state  out  WIDTH  current LFSR register, for debug.
- lockup  out  1  one-cycle pulse: a zero state/seed was replaced by 1.

Behaviour:
- Reset (rst=0, async):
  - state = SEED (0 becomes 1).
  - rand_valid = 0, rand_out = 0, lockup = 0.
- Step function: step(s) = (s >> 1) ^ (s[0] ? TAPS : 0).
- Candidate: cand = step(state)[OUT_W-1:0].
- Advance condition: adv = en & (~rand_valid | rand_ready). Per-cycle priority, highest first:
  - 1) seed_load:
    - state <= (seed_in == 0) ? 1 : seed_in.
    - rand_valid <= 0; any pending value is dropped, even if rand_ready=1 in the same cycle.
    - lockup <= (seed_in == 0).
  - 2) state == 0 (defensive): state <= 1, lockup <= 1, rand_valid unchanged.
  - 3) adv:
    - state <= step(state).
    - REJECT=1, cand <= LIMIT: rand_out <= cand, rand_valid <= 1.
    - REJECT=1, cand > LIMIT: rand_valid <= 0; rand_out is held; the LFSR keeps stepping on later cycles until a candidate is accepted.
    - REJECT=0: rand_out <= min(cand, LIMIT), rand_valid <= 1.
  - 4) Otherwise, hold everything; lockup <= 0.
- Handshake:
  - A transfer occurs on any cycle with rand_valid & rand_ready.
  - Stall (rand_valid=1, rand_ready=0): state and rand_out are frozen regardless of en.
  - Back-to-back transfers are supported: one value per cycle while en=1, rand_ready=1 and candidates are accepted.
- Latency: first rand_valid appears 1 cycle after the first cycle with adv=1 and an accepted candidate.
- en=0 with rand_valid=1: the value stays valid and may still be consumed; after consumption rand_valid <= 0.
- Consumption without refill: if rand_ready=1 and adv cannot produce a value (en=0, or a candidate is rejected), rand_valid <= 0 at the next edge.
- Reset mid-stall or mid-rejection: immediate return to reset values.

Test Plan:
- Reset/defaults (WIDTH=16, TAPS=16'hB400, LIMIT=15): hold rst=0 → rand_valid=0, lfsr_state=16'h0001. Release with en=1, rand_ready=1 → lfsr_state=16'hB400, then 16'h5A00; rand_out=0 each cycle, rand_valid=1 from the cycle after the first step.
- Rejection (LIMIT=9, REJECT=1): seed_load with seed_in=16'hACE1, then en=1, rand_ready=1 → states E270, 7138, 389C, 1C4E, 0E27. Accepted outputs are 0 then 8. Candidates 12 and 14 are rejected with rand_valid=0 for 2 cycles. Next accepted output is 7.
- Saturate (LIMIT=9, REJECT=0, same seed) → rand_out sequence 0, 8, 9, 9, 7 with rand_valid=1 continuously.
- Stall: rand_ready=0 for 5 cycles while rand_valid=1 → rand_out and lfsr_state unchanged. Raise rand_ready → the held value transfers, and stepping resumes the next cycle.
- Zero seed: seed_load with seed_in=0 → lfsr_state=1, lockup high for exactly 1 cycle, rand_valid=0. seed_load during a stall → pending value dropped.
- Period (WIDTH=4, TAPS=4'hC, SEED=1, en=1, rand_ready=1) → state sequence C,6,3,D,A,5,E,7,F,B,9,8,4,2,1. The state returns to 1 after exactly 15 steps and never reaches 0.

Source files
------------

// File: rtl/lfsr_random_stream.sv
// Galois LFSR random source with reseeding, zero-state recovery and bounded output.
// The output register is refilled only when the consumer can take it, and the result goes out over a valid/ready handshake.
module lfsr_random_stream #(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'('hB400),
    parameter int unsigned      LIMIT  = 15,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter bit               REJECT = 1'b1,
    localparam int unsigned     OUT_W  = $clog2(LIMIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    input  logic             rand_ready_i,
    output logic             rand_valid_o,
    output logic [OUT_W-1:0] rand_out_o,
    output logic [WIDTH-1:0] lfsr_state_o,
    output logic             lockup_o
);

    localparam logic [WIDTH-1:0] SEED_V    = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [OUT_W:0]   LIMIT_EXT = (OUT_W + 1)'(LIMIT);
    localparam logic [OUT_W-1:0] LIMIT_OUT = OUT_W'(LIMIT);

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    logic [WIDTH-1:0] state_q, state_d, state_nxt;
    logic [OUT_W-1:0] out_q, out_d, cand;
    logic [OUT_W:0]   cand_ext;
    logic             valid_q, valid_d;
    logic             lockup_q, lockup_d;
    logic             adv, accept;

    assign state_nxt = step(state_q);
    assign cand      = state_nxt[OUT_W-1:0];
    // Extra top bit keeps the range compare meaningful when LIMIT fills OUT_W.
    assign cand_ext  = {1'b0, cand};
    assign accept    = !REJECT || (cand_ext <= LIMIT_EXT);
    assign adv       = en_i & (~valid_q | rand_ready_i);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        valid_d  = valid_q;
        lockup_d = 1'b0;
        if (seed_load_i) begin
            state_d  = (seed_in_i == '0) ? WIDTH'(1) : seed_in_i;
            valid_d  = 1'b0;
            lockup_d = (seed_in_i == '0);
        end else if (state_q == '0) begin
            state_d  = WIDTH'(1);
            lockup_d = 1'b1;
        end else if (adv) begin
            state_d = state_nxt;
            if (accept) begin
                valid_d = 1'b1;
                out_d   = (cand_ext > LIMIT_EXT) ? LIMIT_OUT : cand;
            end else begin
                valid_d = 1'b0;
            end
        end else if (rand_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SEED_V;
            out_q    <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
    end

    assign rand_valid_o = valid_q;
    assign rand_out_o   = out_q;
    assign lfsr_state_o = state_q;
    assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_lfsr_random_stream.sv
// Bench for lfsr_random_stream: four parameterisations, with a scoreboard of expected
// transfer values that a negedge monitor pops on each valid&ready cycle.
module tb_lfsr_random_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en, rdy, sl;
    logic [15:0] seed_in;

    logic        v0, v1, v2, v3, lk0, lk1, lk2, lk3;
    logic [3:0]  o0, o1, o2, o3;
    logic [15:0] st0, st1, st2;
    logic [3:0]  st3;

    int          sel;
    logic        mon_v, mon_r;
    logic [3:0]  mon_o;
    logic [3:0]  sb[$];

    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    lfsr_random_stream #(.WIDTH(16), .TAPS(16'hB400), .LIMIT(15), .SEED(16'h0001), .REJECT(1'b1)) u_def (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .seed_load_i(sl[0]), .seed_in_i(seed_in),
        .rand_ready_i(rdy[0]), .rand_valid_o(v0), .rand_out_o(o0), .lfsr_state_o(st0), .lockup_o(lk0));

    lfsr_random_stream #(.WIDTH(16), .TAPS(16'hB400), .LIMIT(9), .SEED(16'h0001), .REJECT(1'b1)) u_rej (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .seed_load_i(sl[1]), .seed_in_i(seed_in),
        .rand_ready_i(rdy[1]), .rand_valid_o(v1), .rand_out_o(o1), .lfsr_state_o(st1), .lockup_o(lk1));

    lfsr_random_stream #(.WIDTH(16), .TAPS(16'hB400), .LIMIT(9), .SEED(16'h0001), .REJECT(1'b0)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]), .seed_load_i(sl[2]), .seed_in_i(seed_in),
        .rand_ready_i(rdy[2]), .rand_valid_o(v2), .rand_out_o(o2), .lfsr_state_o(st2), .lockup_o(lk2));

    lfsr_random_stream #(.WIDTH(4), .TAPS(4'hC), .LIMIT(15), .SEED(4'h1), .REJECT(1'b1)) u_p4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[3]), .seed_load_i(sl[3]), .seed_in_i(seed_in[3:0]),
        .rand_ready_i(rdy[3]), .rand_valid_o(v3), .rand_out_o(o3), .lfsr_state_o(st3), .lockup_o(lk3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] step16(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_comb begin
        mon_v = 1'b0;
        mon_r = 1'b0;
        mon_o = 4'h0;
        case (sel)
            0: begin mon_v = v0; mon_r = rdy[0]; mon_o = o0; end
            1: begin mon_v = v1; mon_r = rdy[1]; mon_o = o1; end
            2: begin mon_v = v2; mon_r = rdy[2]; mon_o = o2; end
            3: begin mon_v = v3; mon_r = rdy[3]; mon_o = o3; end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && mon_v && mon_r) begin
            if (sb.size() == 0) chk("sb_pop_empty", 32'(sb.size()), 32'd1);
            else chk("sb_data", 32'(mon_o), 32'(sb.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] m;
        logic        mv;
        logic [3:0]  sv;
        logic [15:0] rej_st[5];
        logic        rej_v[5];
        logic [3:0]  p4_st[15];

        rej_st = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27};
        rej_v  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        p4_st  = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

        rst_n = 1'b0; en = '0; rdy = '0; sl = '0; seed_in = '0; sel = 0;
        repeat (3) cyc();
        chk("rst_state", 32'(st0), 32'h0001);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_out", 32'(o0), 32'd0);
        chk("rst_lockup", 32'(lk0), 32'd0);
        chk("rst_p4_state", 32'(st3), 32'h1);

        // default stream, free-running
        rst_n = 1'b1; en[0] = 1'b1; rdy[0] = 1'b1; m = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            m = step16(m);
            sb.push_back(m[3:0]);
            cyc();
            chk("def_state", 32'(st0), 32'(m));
            chk("def_valid", 32'(v0), 32'd1);
            if (i == 0) chk("def_first_state", 32'(st0), 32'hB400);
            if (i == 1) chk("def_second_state", 32'(st0), 32'h5A00);
        end
        en[0] = 1'b0;
        cyc();
        chk("def_drain_valid", 32'(v0), 32'd0);
        chk("def_drain_state", 32'(st0), 32'(m));
        chk("def_sb_empty", 32'(sb.size()), 32'd0);

        // stall with a pending value
        en[0] = 1'b1; rdy[0] = 1'b0;
        m = step16(m); sv = m[3:0]; sb.push_back(sv);
        cyc();
        chk("stall_valid0", 32'(v0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_state", 32'(st0), 32'(m));
            chk("stall_out", 32'(o0), 32'(sv));
            chk("stall_valid", 32'(v0), 32'd1);
        end
        rdy[0] = 1'b1;
        m = step16(m); sb.push_back(m[3:0]);
        cyc();
        chk("resume_state", 32'(st0), 32'(m));
        en[0] = 1'b0;
        cyc();
        chk("resume_drain_valid", 32'(v0), 32'd0);
        chk("resume_sb_empty", 32'(sb.size()), 32'd0);

        // random enable/ready against a small cycle model
        mv = 1'b0;
        for (int i = 0; i < 60; i++) begin
            en[0]  = 1'($urandom_range(0, 1));
            rdy[0] = 1'($urandom_range(0, 1));
            if (en[0] && (!mv || rdy[0])) begin
                m = step16(m);
                sb.push_back(m[3:0]);
                mv = 1'b1;
            end else if (rdy[0]) begin
                mv = 1'b0;
            end
            cyc();
            chk("rnd_valid", 32'(v0), 32'(mv));
            chk("rnd_state", 32'(st0), 32'(m));
        end
        en[0] = 1'b0; rdy[0] = 1'b1;
        cyc();
        chk("rnd_drain_valid", 32'(v0), 32'd0);
        chk("rnd_sb_empty", 32'(sb.size()), 32'd0);

        // zero seed over a pending value
        en[0] = 1'b1; rdy[0] = 1'b0;
        cyc();
        chk("pend_valid", 32'(v0), 32'd1);
        en[0] = 1'b0; sl[0] = 1'b1; seed_in = 16'h0000;
        cyc();
        chk("zs_state", 32'(st0), 32'h0001);
        chk("zs_lockup", 32'(lk0), 32'd1);
        chk("zs_valid", 32'(v0), 32'd0);
        sl[0] = 1'b0;
        cyc();
        chk("zs_lockup_clr", 32'(lk0), 32'd0);
        chk("zs_state_hold", 32'(st0), 32'h0001);

        // rejection sampling, LIMIT=9
        sel = 1; sl[1] = 1'b1; seed_in = 16'hACE1;
        cyc();
        chk("rej_seed_state", 32'(st1), 32'hACE1);
        chk("rej_seed_lockup", 32'(lk1), 32'd0);
        sl[1] = 1'b0; en[1] = 1'b1; rdy[1] = 1'b1;
        sb.push_back(4'd0); sb.push_back(4'd8); sb.push_back(4'd7);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rej_state", 32'(st1), 32'(rej_st[i]));
            chk("rej_valid", 32'(v1), 32'(rej_v[i]));
        end
        en[1] = 1'b0;
        cyc();
        chk("rej_drain_valid", 32'(v1), 32'd0);
        chk("rej_sb_empty", 32'(sb.size()), 32'd0);

        // saturation, LIMIT=9
        sel = 2; sl[2] = 1'b1; seed_in = 16'hACE1;
        cyc();
        sl[2] = 1'b0; en[2] = 1'b1; rdy[2] = 1'b1;
        sb.push_back(4'd0); sb.push_back(4'd8); sb.push_back(4'd9); sb.push_back(4'd9); sb.push_back(4'd7);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("sat_state", 32'(st2), 32'(rej_st[i]));
            chk("sat_valid", 32'(v2), 32'd1);
        end
        en[2] = 1'b0;
        cyc();
        chk("sat_sb_empty", 32'(sb.size()), 32'd0);

        // full period of the 4-bit generator
        sel = 3; en[3] = 1'b1; rdy[3] = 1'b1;
        for (int i = 0; i < 15; i++) sb.push_back(p4_st[i]);
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("p4_state", 32'(st3), 32'(p4_st[i]));
        end
        en[3] = 1'b0;
        cyc();
        chk("p4_sb_empty", 32'(sb.size()), 32'd0);

        // asynchronous reset in the middle of a stall
        sel = 0; en[0] = 1'b1; rdy[0] = 1'b0;
        cyc();
        chk("mr_pre_valid", 32'(v0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(v0), 32'd0);
        chk("mr_state", 32'(st0), 32'h0001);
        chk("mr_out", 32'(o0), 32'd0);
        en[0] = 1'b0;
        #1 rst_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
